// File: rtl/wb_port_arbiter_if.sv
// Signal bundle joining the MEM/WB writeback path, the CGRA result port and the
// register-file write port around wb_port_arbiter.
interface wb_port_arbiter_if;
  logic        wb_regwrite_i;
  logic [4:0]  wb_rdaddr_i;
  logic [31:0] wb_data_i;
  logic        cgra_valid_i;
  logic [4:0]  cgra_rdaddr_i;
  logic [31:0] cgra_data_i;
  logic        cgra_ready_o;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        stall_o;
  logic [31:0] busy_regs_o;

  // Arbiter side
  modport slave (
    input  wb_regwrite_i,
    input  wb_rdaddr_i,
    input  wb_data_i,
    input  cgra_valid_i,
    input  cgra_rdaddr_i,
    input  cgra_data_i,
    output cgra_ready_o,
    output rf_we_o,
    output rf_waddr_o,
    output rf_wdata_o,
    output stall_o,
    output busy_regs_o
  );

  // Pipeline / CGRA / register-file side
  modport master (
    output wb_regwrite_i,
    output wb_rdaddr_i,
    output wb_data_i,
    output cgra_valid_i,
    output cgra_rdaddr_i,
    output cgra_data_i,
    input  cgra_ready_o,
    input  rf_we_o,
    input  rf_waddr_o,
    input  rf_wdata_o,
    input  stall_o,
    input  busy_regs_o
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between the pipeline writeback and a
// queued CGRA result stream, with a starvation guard that briefly stalls the pipeline.
module wb_port_arbiter #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  wb_port_arbiter_if.slave bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [7:0]    LIMIT_C = 8'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FORCE = 2'd2
  } state_t;

  // One-hot register mask; x0 never reports busy.
  function automatic logic [31:0] rd_onehot(input logic [4:0] rd);
    logic [31:0] v;
    v     = 32'd0;
    v[rd] = 1'b1;
    v[0]  = 1'b0;
    return v;
  endfunction

  state_t          state_r;
  state_t          state_next_s;
  state_t          post_pop_state_s;
  logic [CW-1:0]   count_r;
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [7:0]      starve_r;
  logic [7:0]      starve_next_s;
  logic [7:0]      starve_inc_s;
  logic [4:0]      rd_mem_r   [DEPTH];
  logic [31:0]     data_mem_r [DEPTH];

  logic            pipe_eff_s;
  logic            ready_s;
  logic            push_s;
  logic            store_s;
  logic            pop_s;
  logic            stall_s;
  logic            rf_we_s;
  logic [4:0]      rf_waddr_s;
  logic [31:0]     rf_wdata_s;
  logic [4:0]      head_rd_s;
  logic [31:0]     head_data_s;
  logic [31:0]     busy_s;
  logic [AW-1:0]   offs_s;

  assign pipe_eff_s   = bus.wb_regwrite_i && (bus.wb_rdaddr_i != 5'd0);
  assign push_s       = bus.cgra_valid_i && ready_s;
  // Results for x0 complete the handshake but are dropped here.
  assign store_s      = push_s && (bus.cgra_rdaddr_i != 5'd0);
  assign head_rd_s    = rd_mem_r[rd_ptr_r];
  assign head_data_s  = data_mem_r[rd_ptr_r];
  assign starve_inc_s = starve_r + 8'd1;
  assign post_pop_state_s = ((count_r == CW'(1)) && !store_s) ? ST_IDLE : ST_WAIT;

  // Ready uses the pre-pop occupancy; reset presents an empty FIFO.
  always_comb begin
    ready_s = 1'b1;
    if (rst_i) begin
      ready_s = 1'b1;
    end else begin
      ready_s = (count_r < DEPTH_C);
    end
  end

  // Next-state, grant and register-file port selection.
  always_comb begin
    state_next_s  = state_r;
    starve_next_s = starve_r;
    pop_s         = 1'b0;
    stall_s       = 1'b0;
    rf_we_s       = 1'b0;
    rf_waddr_s    = bus.wb_rdaddr_i;
    rf_wdata_s    = bus.wb_data_i;
    if (rst_i) begin
      state_next_s  = ST_IDLE;
      starve_next_s = 8'd0;
      rf_we_s       = pipe_eff_s;
    end else begin
      case (state_r)
        ST_IDLE: begin
          starve_next_s = 8'd0;
          rf_we_s       = pipe_eff_s;
          if (store_s) begin
            state_next_s = ST_WAIT;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (pipe_eff_s) begin
            rf_we_s       = 1'b1;
            starve_next_s = starve_inc_s;
            if (starve_inc_s >= LIMIT_C) begin
              state_next_s = ST_FORCE;
            end else begin
              state_next_s = ST_WAIT;
            end
          end else begin
            pop_s         = 1'b1;
            rf_we_s       = 1'b1;
            rf_waddr_s    = head_rd_s;
            rf_wdata_s    = head_data_s;
            starve_next_s = 8'd0;
            state_next_s  = post_pop_state_s;
          end
        end
        ST_FORCE: begin
          // The frozen MEM/WB stage re-presents its write next cycle.
          stall_s       = 1'b1;
          pop_s         = 1'b1;
          rf_we_s       = 1'b1;
          rf_waddr_s    = head_rd_s;
          rf_wdata_s    = head_data_s;
          starve_next_s = 8'd0;
          state_next_s  = post_pop_state_s;
        end
        default: begin
          state_next_s  = ST_IDLE;
          starve_next_s = 8'd0;
        end
      endcase
    end
  end

  // Busy scoreboard: OR of destination masks over the occupied FIFO slots.
  always_comb begin
    busy_s = 32'd0;
    offs_s = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      offs_s = AW'(i) - rd_ptr_r;
      if (CW'(offs_s) < count_r) begin
        busy_s = busy_s | rd_onehot(rd_mem_r[i]);
      end else begin
        busy_s = busy_s;
      end
    end
    if (rst_i) begin
      busy_s = 32'd0;
    end else begin
      busy_s[0] = 1'b0;
    end
  end

  // FSM state, FIFO pointers, occupancy and starvation counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r  <= ST_IDLE;
      count_r  <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      starve_r <= 8'd0;
    end else begin
      state_r  <= state_next_s;
      starve_r <= starve_next_s;
      if (store_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_r + CW'(store_s) - CW'(pop_s);
    end
  end

  // FIFO storage; contents are only meaningful within the occupied window.
  always_ff @(posedge clk_i) begin
    if (store_s && !rst_i) begin
      rd_mem_r[wr_ptr_r]   <= bus.cgra_rdaddr_i;
      data_mem_r[wr_ptr_r] <= bus.cgra_data_i;
    end
  end

  assign bus.cgra_ready_o = ready_s;
  assign bus.rf_we_o      = rf_we_s && (rf_waddr_s != 5'd0);
  assign bus.rf_waddr_o   = rf_waddr_s;
  assign bus.rf_wdata_o   = rf_wdata_s;
  assign bus.stall_o      = stall_s;
  assign bus.busy_regs_o  = busy_s;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter against a queue-based reference of the
// arbitration rules, plus hand-computed literal checks.
module tb_wb_port_arbiter;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic clk_i = 1'b0;
  logic rst_i;
  int   total = 0;
  int   bad   = 0;

  wb_port_arbiter_if bus ();

  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];
  int   starve = 0;
  bit   force_m = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic drv(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic cv, input logic [4:0] ca, input logic [31:0] cd);
    bus.wb_regwrite_i = we;
    bus.wb_rdaddr_i   = wa;
    bus.wb_data_i     = wd;
    bus.cgra_valid_i  = cv;
    bus.cgra_rdaddr_i = ca;
    bus.cgra_data_i   = cd;
  endtask

  // Expected outputs this cycle from the reference queue, compared mid-cycle.
  task automatic look();
    logic        pipe, exp_we, exp_ready, exp_stall;
    logic [4:0]  exp_a;
    logic [31:0] exp_d, exp_busy;
    #3;
    pipe      = bus.wb_regwrite_i && (bus.wb_rdaddr_i != 5'd0);
    exp_busy  = 32'd0;
    exp_stall = 1'b0;
    exp_we    = pipe;
    exp_a     = bus.wb_rdaddr_i;
    exp_d     = bus.wb_data_i;
    exp_ready = 1'b1;
    if (!rst_i) begin
      exp_ready = (q.size() < DEPTH);
      foreach (q[i]) exp_busy[q[i].rd] = 1'b1;
      if (q.size() > 0 && (force_m || !pipe)) begin
        exp_we    = 1'b1;
        exp_a     = q[0].rd;
        exp_d     = q[0].d;
        exp_stall = force_m;
      end
    end
    chk("m_ready", 32'(bus.cgra_ready_o), 32'(exp_ready));
    chk("m_stall", 32'(bus.stall_o), 32'(exp_stall));
    chk("m_busy", bus.busy_regs_o, exp_busy);
    chk("m_we", 32'(bus.rf_we_o), 32'(exp_we));
    if (exp_we) begin
      chk("m_waddr", 32'(bus.rf_waddr_o), 32'(exp_a));
      chk("m_wdata", bus.rf_wdata_o, exp_d);
    end
  endtask

  // Advance the reference across the coming clock edge, then step past it.
  task automatic adv();
    logic pipe;
    bit   full;
    pipe = bus.wb_regwrite_i && (bus.wb_rdaddr_i != 5'd0);
    if (rst_i) begin
      q.delete();
      starve  = 0;
      force_m = 1'b0;
    end else begin
      full = (q.size() >= DEPTH);
      if (q.size() > 0) begin
        if (force_m || !pipe) begin
          q.delete(0);
          starve  = 0;
          force_m = 1'b0;
        end else begin
          starve++;
          if (starve >= LIMIT) begin
            force_m = 1'b1;
            starve  = 0;
          end
        end
      end
      if (bus.cgra_valid_i && !full && bus.cgra_rdaddr_i != 5'd0)
        q.push_back({bus.cgra_rdaddr_i, bus.cgra_data_i});
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic cyc();
    look();
    adv();
  endtask

  initial begin
    logic [4:0] rds [4];
    int         grants;
    bit         seen;
    bit         hit;
    rds = '{5'd4, 5'd5, 5'd6, 5'd8};

    rst_i = 1'b1;
    drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(posedge clk_i);
    #1;
    cyc();
    look();
    chk("rst_ready", 32'(bus.cgra_ready_o), 32'd1);
    chk("rst_stall", 32'(bus.stall_o), 32'd0);
    chk("rst_busy", bus.busy_regs_o, 32'd0);
    chk("rst_we", 32'(bus.rf_we_o), 32'd0);
    adv();
    rst_i = 1'b0;

    // Idle pass-through
    drv(1'b1, 5'd5, 32'hA5A5_A5A5, 1'b0, 5'd0, 32'd0);
    look();
    chk("idle_we", 32'(bus.rf_we_o), 32'd1);
    chk("idle_waddr", 32'(bus.rf_waddr_o), 32'd5);
    chk("idle_wdata", bus.rf_wdata_o, 32'hA5A5_A5A5);
    chk("idle_stall", 32'(bus.stall_o), 32'd0);
    adv();
    drv(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0);
    look();
    chk("x0_we", 32'(bus.rf_we_o), 32'd0);
    adv();

    // Gap drain
    drv(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h11);
    look();
    chk("push7_nobypass", 32'(bus.rf_we_o), 32'd0);
    adv();
    drv(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h22);
    look();
    chk("drain7_waddr", 32'(bus.rf_waddr_o), 32'd7);
    chk("drain7_wdata", bus.rf_wdata_o, 32'h11);
    chk("drain7_busy", bus.busy_regs_o, 32'h0000_0080);
    adv();
    drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    look();
    chk("drain9_waddr", 32'(bus.rf_waddr_o), 32'd9);
    chk("drain9_busy", bus.busy_regs_o, 32'h0000_0200);
    adv();
    look();
    chk("drained_busy", bus.busy_regs_o, 32'd0);
    adv();

    // Starvation
    drv(1'b1, 5'd1, 32'h100, 1'b1, 5'd12, 32'hCC);
    cyc();
    grants = 0;
    seen   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!seen) begin
        drv(1'b1, 5'd1, 32'h101 + 32'(i), 1'b0, 5'd0, 32'd0);
        look();
        if (bus.stall_o) begin
          seen = 1'b1;
          chk("force_waddr", 32'(bus.rf_waddr_o), 32'd12);
          chk("force_wdata", bus.rf_wdata_o, 32'hCC);
        end else if (bus.rf_we_o && bus.rf_waddr_o == 5'd1) begin
          grants++;
        end
        adv();
      end
    end
    chk("starve_grants", 32'(grants), 32'd8);
    chk("force_seen", 32'(seen), 32'd1);
    drv(1'b1, 5'd1, 32'h200, 1'b0, 5'd0, 32'd0);
    look();
    chk("resume_stall", 32'(bus.stall_o), 32'd0);
    chk("resume_wdata", bus.rf_wdata_o, 32'h200);
    adv();

    // Full boundary
    for (int k = 0; k < 4; k++) begin
      drv(1'b1, 5'd2, 32'h2000 + 32'(k), 1'b1, rds[k], 32'h40 + 32'(k));
      cyc();
    end
    drv(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'hAA);
    look();
    chk("full_ready", 32'(bus.cgra_ready_o), 32'd0);
    chk("full_pop_waddr", 32'(bus.rf_waddr_o), 32'd4);
    adv();
    drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    look();
    chk("ready_after_pop", 32'(bus.cgra_ready_o), 32'd1);
    chk("no_push10", 32'(bus.busy_regs_o[10]), 32'd0);
    adv();
    cyc();
    cyc();
    cyc();

    // Duplicate rd and x0
    drv(1'b1, 5'd2, 32'h5000, 1'b1, 5'd3, 32'h31);
    cyc();
    drv(1'b1, 5'd2, 32'h5001, 1'b1, 5'd3, 32'h32);
    cyc();
    drv(1'b1, 5'd2, 32'h5002, 1'b1, 5'd0, 32'h30);
    look();
    chk("x0_ready", 32'(bus.cgra_ready_o), 32'd1);
    adv();
    drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    look();
    chk("dup1_wdata", bus.rf_wdata_o, 32'h31);
    chk("dup1_busy", bus.busy_regs_o, 32'h0000_0008);
    adv();
    look();
    chk("dup2_wdata", bus.rf_wdata_o, 32'h32);
    chk("dup2_busy", bus.busy_regs_o, 32'h0000_0008);
    adv();
    look();
    chk("dup_done_busy", bus.busy_regs_o, 32'd0);
    chk("dup_done_we", 32'(bus.rf_we_o), 32'd0);
    adv();

    // Reset while in FORCE with three entries queued
    for (int k = 0; k < 3; k++) begin
      drv(1'b1, 5'd2, 32'h3000, 1'b1, 5'd13 + 5'(k), 32'h70 + 32'(k));
      cyc();
    end
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!hit) begin
        drv(1'b1, 5'd2, 32'h3100 + 32'(i), 1'b0, 5'd0, 32'd0);
        if (bus.stall_o) hit = 1'b1;
        else cyc();
      end
    end
    chk("force_reached", 32'(hit), 32'd1);
    rst_i = 1'b1;
    look();
    chk("rstf_stall", 32'(bus.stall_o), 32'd0);
    chk("rstf_busy", bus.busy_regs_o, 32'd0);
    adv();
    rst_i = 1'b0;
    drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    look();
    chk("post_rst_stall", 32'(bus.stall_o), 32'd0);
    chk("post_rst_busy", bus.busy_regs_o, 32'd0);
    chk("post_rst_ready", 32'(bus.cgra_ready_o), 32'd1);
    chk("post_rst_we", 32'(bus.rf_we_o), 32'd0);
    adv();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4: CGRA result FIFO entries, power of two, 2..16.
REQ-002 SHALL have parameter STARVE_LIMIT, default 8: consecutive lost-arbitration cycles before a forced slot, 1..255.
REQ-003 SHALL have port clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port wb_regwrite_i  in  1  pipeline writeback request, driven from the MEM/WB stage.
REQ-006 SHALL have port wb_rdaddr_i  in  5  pipeline destination register.
REQ-007 SHALL have port wb_data_i  in  32  pipeline writeback data, after the MemToReg mux.
REQ-008 SHALL have port cgra_valid_i  in  1  CGRA result offered.
REQ-009 SHALL have port cgra_rdaddr_i  in  5  CGRA result destination register.
REQ-010 SHALL have port cgra_data_i  in  32  CGRA result data.
REQ-011 SHALL have port cgra_ready_o  out  1  FIFO can accept a result.
REQ-012 SHALL have port rf_we_o  out  1  register-file write enable.
REQ-013 SHALL have port rf_waddr_o  out  5  register-file write address.
REQ-014 SHALL have port rf_wdata_o  out  32  register-file write data.
REQ-015 SHALL have port stall_o  out  1  freeze request to the pipeline: hold MEM/WB and upstream for this cycle.
REQ-016 SHALL have port busy_regs_o  out  32  bit n set while any queued CGRA entry targets xn.

Function
REQ-017 SHALL transfer a CGRA result on each rising edge where cgra_valid_i and cgra_ready_o are both 1.
REQ-018 SHALL drive cgra_ready_o = (count < DEPTH), using pre-pop count only; when full, a same-cycle pop does not enable a push.
REQ-019 SHALL complete the handshake for a CGRA result with cgra_rdaddr_i = 0 but never store it.
REQ-020 SHALL treat a pipeline request as effective only when wb_regwrite_i = 1 and wb_rdaddr_i != 0.
REQ-021 SHALL use three FSM states: IDLE (FIFO empty), WAIT (FIFO non-empty), FORCE (forced CGRA slot).
REQ-022 SHALL drive rf_* combinationally, with zero latency, from the current state and inputs.
REQ-023 In IDLE, SHALL pass an effective pipeline write to rf_*; otherwise rf_we_o = 0.
REQ-024 In IDLE, a pushed result SHALL go to the FIFO and not bypass to rf_*.
REQ-025 In WAIT with an effective pipeline request, SHALL grant the pipeline and increment the starve counter.
REQ-026 In WAIT with no effective pipeline request, SHALL write and pop the FIFO head and clear the starve counter.
REQ-027 In WAIT, SHALL move to FORCE on the edge where the starve counter reaches STARVE_LIMIT.
REQ-028 In FORCE, SHALL assert stall_o = 1 and write and pop the FIFO head.
REQ-029 In FORCE, SHALL ignore all wb_* inputs, which are re-presented next cycle by the frozen MEM/WB stage.
REQ-030 In FORCE, SHALL clear the starve counter.
REQ-031 SHALL hold stall_o = 1 in FORCE only, for exactly one cycle per entry into FORCE.
REQ-032 SHALL select the next state after a pop as IDLE if the post-pop count is 0, else WAIT, including a same-cycle push.
REQ-033 SHALL write FIFO entries in push order.
REQ-034 SHALL wrap read and write pointers modulo DEPTH and track count 0..DEPTH, with simultaneous push and pop leaving count unchanged.
REQ-035 SHALL form busy_regs_o as the OR of one-hot rd over valid entries, bit 0 always 0.
REQ-036 SHALL keep a register's busy bit set while any duplicate rd entry remains queued.
REQ-037 SHALL never assert rf_we_o with rf_waddr_o = 0.

Reset
REQ-038 While rst_i = 1 at a clock edge, SHALL go to IDLE and clear count, pointers and starve counter.
REQ-039 Reset SHALL discard FIFO contents, including in-flight entries mid-operation.
REQ-040 During and after reset until the next push, SHALL drive cgra_ready_o = 1, stall_o = 0, busy_regs_o = 0 and rf_we_o = 0 (absent a pipeline write).
REQ-041 SHALL let reset take priority over every simultaneous push, pop or FORCE entry.

Verification
REQ-042 Idle pass-through: wb_regwrite_i=1, rd=5, data=0xA5A5A5A5, FIFO empty -> same cycle rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0xA5A5A5A5; stall_o=0.
REQ-043 Gap drain: push rd=7/0x11 and rd=9/0x22, pipeline idle -> rd=7 written on the cycle after its push, then rd=9; busy_regs_o bits 7,9 clear as each pops.
REQ-044 Starvation: one entry queued, pipeline writes every cycle, STARVE_LIMIT=8 -> 8 pipeline grants, then 1 cycle stall_o=1 writing the CGRA entry, then pipeline resumes.
REQ-045 Full boundary: 4 pushes with pipeline busy -> cgra_ready_o=0; a pop while cgra_valid_i=1 takes no push that cycle; ready=1 the next cycle.
REQ-046 Duplicate rd and x0: push rd=3, rd=3, rd=0 -> rd=0 accepted but not stored; bit 3 stays set until the second rd=3 pops.
REQ-047 Reset mid-operation: rst_i=1 for one cycle in FORCE with 3 entries queued -> next cycle IDLE, stall_o=0, busy_regs_o=0, cgra_ready_o=1, no CGRA write.
